pc_counter_16bit: RTL and testbench

Registered 16-bit program-counter stage that drives the existing `incrementer_16bit` combinational block and latches its sum output as the next count. It supports parallel load, single-step increment, and a counted burst of up to 15 increments with a busy/done handshake. It also keeps a sticky wrap flag taken from the incrementer's MSB carry. It sits directly upstream and downstream of the incrementer: `q` feeds the incrementer's `a`, and the incrementer's `s`/`c[15]` return as next-state data.

---
 rtl/pc_counter_16bit_if.sv | 27 ++
 rtl/pc_counter_16bit.sv | 121 ++++++++++++
 tb/tb_pc_counter_16bit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pc_counter_16bit_if.sv
// Command/status bundle between a sequencer and the 16-bit program counter.
// Latency: none, this file only groups wires.
// Backpressure: none; busy tells the sequencer that inc/start are being ignored.
interface pc_counter_16bit_if;
  logic        ld;
  logic [15:0] d;
  logic        inc;
  logic        start;
  logic [3:0]  n;
  logic        clr_ovf;
  logic [15:0] q;
  logic        busy;
  logic        done;
  logic        ovf;

  // Sequencer side: issues commands and observes the count
  modport master (
    output ld, d, inc, start, n, clr_ovf,
    input  q, busy, done, ovf
  );

  // Counter side: consumes commands and reports the count
  modport slave (
    input  ld, d, inc, start, n, clr_ovf,
    output q, busy, done, ovf
  );
endinterface

// File: rtl/pc_counter_16bit.sv
// Combinational +1 ripple incrementer; c[i] is the carry out of bit i.
// Latency: 0 cycles, a 16-stage ripple from a[0] to c[15].
// Backpressure: none.
module incrementer_16bit (
  input  logic [15:0] a,
  output logic [15:0] s,
  output logic [15:0] c
);
  logic [16:0] cy;

  assign cy[0] = 1'b1;

  for (genvar i = 0; i < 16; i++) begin : g_bit
    assign s[i]    = a[i] ^ cy[i];
    assign cy[i+1] = a[i] & cy[i];
  end

  assign c = cy[16:1];
endmodule

// Registered 16-bit program counter: load, single step, counted burst, sticky wrap flag.
// Latency: ld/inc land in q one cycle later; a burst of n ends with done n+1 cycles after start.
// Backpressure: inc and start are dropped while busy; start is dropped in the done cycle.
module pc_counter_16bit (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_counter_16bit_if.slave     bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  rem, rem_nxt;
  logic [15:0] q, q_nxt;
  logic        ovf, ovf_nxt;
  logic        step;
  logic        busy, done;

  logic [15:0] sum;
  logic        wrap;
  logic [14:0] carry_unused;

  // The count path goes through the shared incrementer; only the MSB carry is needed.
  incrementer_16bit u_inc (
    .a (q),
    .s (sum),
    .c ({wrap, carry_unused})
  );

  // State, remaining burst count, count and wrap flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= 4'd0;
      q     <= 16'h0000;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      q     <= q_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Next state: load beats everything, a running burst ignores inc/start
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    q_nxt     = q;
    step      = 1'b0;
    if (bus.ld) begin
      q_nxt     = bus.d;
      state_nxt = IDLE;
      rem_nxt   = 4'd0;
    end else begin
      case (state)
        RUN: begin
          step    = 1'b1;
          rem_nxt = rem - 4'd1;
          if (rem == 4'd1) state_nxt = DONE;
        end
        IDLE: begin
          if (bus.start) begin
            // A zero-length burst completes immediately without touching q
            if (bus.n != 4'd0) begin
              rem_nxt   = bus.n;
              state_nxt = RUN;
            end else begin
              state_nxt = DONE;
            end
          end else if (bus.inc) begin
            step = 1'b1;
          end
        end
        DONE: begin
          state_nxt = IDLE;
          if (bus.inc) step = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (step) q_nxt = sum;
    // Set has priority over a same-edge clear so a wrap is never lost
    ovf_nxt = (step & wrap) | (ovf & ~bus.clr_ovf);
  end

  // Handshake outputs decoded from the registered state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign bus.q    = q;
  assign bus.ovf  = ovf;
  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: tb/tb_pc_counter_16bit.sv
// Directed bench for pc_counter_16bit with a queue of expected post-edge outputs.
// Latency: each expectation is checked 1 time unit after the edge it belongs to.
// Backpressure: none; stimulus is a fixed linear sequence.
module tb_pc_counter_16bit;
  logic clk;
  logic rst_n;

  pc_counter_16bit_if bus ();

  pc_counter_16bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [15:0] q;
    logic        busy;
    logic        done;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, got, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    chk(e.tag, "q",    bus.q,           e.q);
    chk(e.tag, "busy", {15'd0, bus.busy}, {15'd0, e.busy});
    chk(e.tag, "done", {15'd0, bus.done}, {15'd0, e.done});
    chk(e.tag, "ovf",  {15'd0, bus.ovf},  {15'd0, e.ovf});
  endtask

  // Expectation for the outputs after the next rising edge
  task automatic step(input string tag, input logic [15:0] q, input logic b, input logic d, input logic o);
    sb.push_back('{tag, q, b, d, o});
    @(posedge clk);
    #1;
    compare_front();
  endtask

  // Expectation for the outputs right now (asynchronous effects)
  task automatic now_check(input string tag, input logic [15:0] q, input logic b, input logic d, input logic o);
    sb.push_back('{tag, q, b, d, o});
    #1;
    compare_front();
  endtask

  task automatic quiet();
    bus.ld = 1'b0; bus.d = 16'h0000; bus.inc = 1'b0;
    bus.start = 1'b0; bus.n = 4'd0; bus.clr_ovf = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    quiet();
    #1;
    now_check("reset", 16'h0000, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset then step
    bus.ld = 1'b1; bus.d = 16'h5555;
    step("ld5555", 16'h5555, 0, 0, 0);
    quiet();
    #2; rst_n = 1'b0;
    now_check("async_rst", 16'h0000, 0, 0, 0);
    #1; rst_n = 1'b1;
    bus.inc = 1'b1;
    step("inc1", 16'h0001, 0, 0, 0);
    step("inc2", 16'h0002, 0, 0, 0);
    step("inc3", 16'h0003, 0, 0, 0);

    // Load and wrap
    quiet(); bus.ld = 1'b1; bus.d = 16'hFFFE;
    step("ldFFFE", 16'hFFFE, 0, 0, 0);
    quiet(); bus.inc = 1'b1;
    step("incFFFF", 16'hFFFF, 0, 0, 0);
    step("wrap", 16'h0000, 0, 0, 1);
    quiet(); bus.clr_ovf = 1'b1;
    step("clr", 16'h0000, 0, 0, 0);
    quiet(); bus.ld = 1'b1; bus.d = 16'hFFFF;
    step("ldFFFF", 16'hFFFF, 0, 0, 0);
    quiet(); bus.inc = 1'b1; bus.clr_ovf = 1'b1;
    step("set_wins", 16'h0000, 0, 0, 1);
    quiet(); bus.clr_ovf = 1'b1;
    step("clr2", 16'h0000, 0, 0, 0);

    // Burst of 5 with inc/start noise while busy
    quiet(); bus.ld = 1'b1; bus.d = 16'h0010;
    step("ld0010", 16'h0010, 0, 0, 0);
    quiet(); bus.start = 1'b1; bus.n = 4'd5;
    step("b5_e0", 16'h0010, 1, 0, 0);
    bus.inc = 1'b1; bus.start = 1'b1; bus.n = 4'd3;
    step("b5_e1", 16'h0011, 1, 0, 0);
    step("b5_e2", 16'h0012, 1, 0, 0);
    step("b5_e3", 16'h0013, 1, 0, 0);
    step("b5_e4", 16'h0014, 1, 0, 0);
    step("b5_e5", 16'h0015, 0, 1, 0);
    quiet();
    step("b5_idle", 16'h0015, 0, 0, 0);

    // Zero-length burst
    bus.ld = 1'b1; bus.d = 16'h1234;
    step("ld1234", 16'h1234, 0, 0, 0);
    quiet(); bus.start = 1'b1; bus.n = 4'd0;
    step("b0_done", 16'h1234, 0, 1, 0);
    quiet();
    step("b0_idle", 16'h1234, 0, 0, 0);

    // Abort a burst of 8 with a load on the 3rd RUN edge
    bus.ld = 1'b1; bus.d = 16'h0000;
    step("ld0000", 16'h0000, 0, 0, 0);
    quiet(); bus.start = 1'b1; bus.n = 4'd8;
    step("b8_e0", 16'h0000, 1, 0, 0);
    quiet();
    step("b8_e1", 16'h0001, 1, 0, 0);
    step("b8_e2", 16'h0002, 1, 0, 0);
    bus.ld = 1'b1; bus.d = 16'hABCD;
    step("abort", 16'hABCD, 0, 0, 0);
    quiet();
    for (int i = 0; i < 4; i++) step("post_abort", 16'hABCD, 0, 0, 0);

    // Reset mid-burst, with ovf set beforehand so its reset is visible
    bus.ld = 1'b1; bus.d = 16'hFFFF;
    step("ldFFFF_b", 16'hFFFF, 0, 0, 0);
    quiet(); bus.inc = 1'b1;
    step("wrap_b", 16'h0000, 0, 0, 1);
    quiet(); bus.start = 1'b1; bus.n = 4'd15;
    step("b15_e0", 16'h0000, 1, 0, 1);
    quiet();
    step("b15_e1", 16'h0001, 1, 0, 1);
    step("b15_e2", 16'h0002, 1, 0, 1);
    step("b15_e3", 16'h0003, 1, 0, 1);
    step("b15_e4", 16'h0004, 1, 0, 1);
    #2; rst_n = 1'b0;
    now_check("rst_mid", 16'h0000, 0, 0, 0);
    #1; rst_n = 1'b1;
    step("rst_hold", 16'h0000, 0, 0, 0);
    bus.start = 1'b1; bus.n = 4'd1;
    step("b1_e0", 16'h0000, 1, 0, 0);
    quiet();
    step("b1_e1", 16'h0001, 0, 1, 0);
    step("b1_idle", 16'h0001, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
